dpwm_display_mux: RTL

Parametrised, registered N-channel display source selector for the DPWM front panel. Replaces the fixed two-source frequency/counter selector. Chooses one of `NCH` `WIDTH`-bit data channels for the display path, either by manual select or by timed auto-scan, with optional hold. Reports the active channel index and a change strobe so the display driver can relabel.

---
 rtl/dpwm_display_mux.sv | 109 ++++++++++
 1 files changed

// File: rtl/dpwm_display_mux.sv
// Registered N-channel display source selector with manual select, timed auto-scan and hold.
// Optional post-switch blanking of the display data is enabled by defining DISPMUX_BLANK_EN.
module dpwm_display_mux #(
  parameter int WIDTH = 10,
  parameter int NCH   = 4,
  parameter int DWELL = 50_000_000,
  parameter int BLANK = 2,
  parameter int SELW  = $clog2(NCH)
) (
  input  logic                 clkm,
  input  logic                 reset,
  input  logic [NCH*WIDTH-1:0] ch_data,
  input  logic [SELW-1:0]      sel,
  input  logic                 auto_en,
  input  logic                 hold,
  output logic [WIDTH-1:0]     datodis,
  output logic [SELW-1:0]      ch_idx,
  output logic                 upd
);

  localparam int              DW         = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0]   DWELL_LAST = DW'(DWELL - 1);
  localparam logic [SELW-1:0] IDX_LAST   = SELW'(NCH - 1);

  if (NCH < 2 || DWELL < 1 || BLANK < 1) begin : g_bad_param
    $error("dpwm_display_mux: NCH >= 2, DWELL >= 1 and BLANK >= 1 required");
  end

  logic [SELW-1:0]  idx_q, idx_d;
  logic [DW-1:0]    dwell_q, dwell_d;
  logic [WIDTH-1:0] datodis_q, datodis_d;
  logic             upd_q, upd_d;
  logic             idx_change;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    idx_d   = idx_q;
    dwell_d = dwell_q;
    if (!hold) begin
      if (!auto_en) begin
        dwell_d = '0;
        if (int'(sel) < NCH) idx_d = sel;
      end else if (dwell_q == DWELL_LAST) begin
        dwell_d = '0;
        idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + SELW'(1);
      end else begin
        dwell_d = dwell_q + DW'(1);
      end
    end
    idx_change = (idx_d != idx_q);
    // A manual reselect of another channel must also restart the dwell.
    if (idx_change) dwell_d = '0;
    upd_d = idx_change;
  end

`ifdef DISPMUX_BLANK_EN
  localparam int            BW         = (BLANK > 1) ? $clog2(BLANK) : 1;
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK - 1);

  logic [BW-1:0] blank_q, blank_d;

  // The change edge itself is the first blank cycle, so the counter holds the remaining ones.
  always_comb begin
    blank_d   = blank_q;
    datodis_d = datodis_q;
    if (!hold) begin
      if (idx_change) begin
        blank_d   = BLANK_LAST;
        datodis_d = '0;
      end else if (blank_q != '0) begin
        blank_d   = blank_q - BW'(1);
        datodis_d = '0;
      end else begin
        datodis_d = ch_data[idx_d*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clkm) begin
    if (reset) blank_q <= '0;
    else       blank_q <= blank_d;
  end
`else
  always_comb begin
    datodis_d = datodis_q;
    if (!hold) datodis_d = ch_data[idx_d*WIDTH +: WIDTH];
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clkm) begin
    if (reset) begin
      idx_q     <= '0;
      dwell_q   <= '0;
      datodis_q <= '0;
      upd_q     <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      dwell_q   <= dwell_d;
      datodis_q <= datodis_d;
      upd_q     <= upd_d;
    end
  end

  assign datodis = datodis_q;
  assign ch_idx  = idx_q;
  assign upd     = upd_q;

endmodule
